// File: rtl/alu_operand_sequencer_if.sv
// Switch/key bundle in, held operand set out, for alu_operand_sequencer.
interface alu_operand_sequencer_if #(
    parameter int WIDTH    = 4,
    parameter int OPCODE_W = 4
);
    logic [9:0]          sw;
    logic [3:0]          key;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [OPCODE_W-1:0] opcode;
    logic                valid;
    logic [1:0]          phase;

    modport master (
        output sw,
        output key,
        input  a,
        input  b,
        input  opcode,
        input  valid,
        input  phase
    );

    modport slave (
        input  sw,
        input  key,
        output a,
        output b,
        output opcode,
        output valid,
        output phase
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Debounced ENTER/CLEAR load FSM feeding a, b, opcode to the ALU.
// Optional macro ALU_SEQ_LIVE_PREVIEW_EN: operand under load tracks sw.
module alu_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int OPCODE_W        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic clk,
    input logic rst,
    alu_operand_sequencer_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    pulse;
    logic          enter;
    logic          clear;

    state_t              state;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [OPCODE_W-1:0] op_q;
    logic                valid_q;

    logic unused_in;
    assign unused_in = ^{bus.key[3:2], bus.sw};

    // Levels idle at 1 (released) so a key held through rst still pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 2'b11;
            s2    <= 2'b11;
            lvl   <= 2'b11;
            lvl_d <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= bus.key[1:0];
            s2    <= s1;
            lvl_d <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    lvl[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulse = lvl_d & ~lvl;
    assign enter = pulse[0];
    assign clear = pulse[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            state   <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else if (enter) begin
            unique case (state)
                LOAD_A: begin
                    a_q   <= bus.sw[WIDTH-1:0];
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    b_q   <= bus.sw[WIDTH-1:0];
                    state <= LOAD_OP;
                end
                LOAD_OP: begin
                    op_q    <= bus.sw[OPCODE_W-1:0];
                    valid_q <= 1'b1;
                    state   <= SHOW;
                end
                SHOW: begin
                    valid_q <= 1'b0;
                    state   <= LOAD_A;
                end
                default: state <= LOAD_A;
            endcase
        end else begin
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
            unique case (state)
                LOAD_A:  a_q  <= bus.sw[WIDTH-1:0];
                LOAD_B:  b_q  <= bus.sw[WIDTH-1:0];
                LOAD_OP: op_q <= bus.sw[OPCODE_W-1:0];
                default: ;
            endcase
`else
            state <= state;
`endif
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.opcode = op_q;
    assign bus.valid  = valid_q;
    assign bus.phase  = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a scoreboard queue.
module tb_alu_operand_sequencer;

    localparam int W  = 4;
    localparam int OW = 4;
    localparam int DB = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       v;
        logic [1:0] ph;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    alu_operand_sequencer_if #(.WIDTH(W), .OPCODE_W(OW)) bus ();

    alu_operand_sequencer #(
        .WIDTH(W),
        .OPCODE_W(OW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] ma;
    logic [3:0] mb;
    logic [3:0] mop;
    logic       mv;
    logic [1:0] mph;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.a  = ma;
        e.b  = mb;
        e.op = mop;
        e.v  = mv;
        e.ph = mph;
        return e;
    endfunction

    task automatic cmp(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_vs(string tag, exp_t e);
        cmp({tag, "_a"}, bus.a, e.a);
        cmp({tag, "_b"}, bus.b, e.b);
        cmp({tag, "_op"}, bus.opcode, e.op);
        cmp({tag, "_valid"}, {3'b000, bus.valid}, {3'b000, e.v});
        cmp({tag, "_phase"}, {2'b00, bus.phase}, {2'b00, e.ph});
    endtask

    task automatic pop_check(string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            e = q.pop_front();
            check_vs(tag, e);
        end
    endtask

    task automatic settle(string tag);
        check_vs(tag, model_now());
    endtask

    task automatic model_preview();
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
        case (mph)
            2'd0: ma = bus.sw[3:0];
            2'd1: mb = bus.sw[3:0];
            2'd2: mop = bus.sw[3:0];
            default: ;
        endcase
`endif
    endtask

    task automatic set_sw(logic [9:0] v);
        bus.sw = v;
        tick();
        tick();
        model_preview();
    endtask

    task automatic model_enter();
        case (mph)
            2'd0: begin ma = bus.sw[3:0]; mph = 2'd1; end
            2'd1: begin mb = bus.sw[3:0]; mph = 2'd2; end
            2'd2: begin
                mop = bus.sw[3:0];
                mv  = 1'b1;
                mph = 2'd3;
            end
            default: begin mv = 1'b0; mph = 2'd0; end
        endcase
    endtask

    // Key falls right after an edge; effect must land 7 edges later.
    task automatic press(logic [1:0] m, int hold, string tag);
        exp_t old;
        old = model_now();
        bus.key = {2'b11, ~m};
        if (m[1]) begin
            ma = '0; mb = '0; mop = '0; mv = 1'b0; mph = 2'd0;
        end else begin
            model_enter();
        end
        q.push_back(model_now());
        repeat (6) tick();
        check_vs({tag, "_early"}, old);
        tick();
        pop_check(tag);
        repeat (hold) tick();
        model_preview();
        settle({tag, "_hold"});
        bus.key = 4'hF;
        repeat (8) tick();
        settle({tag, "_rel"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '0; mb = '0; mop = '0; mv = 1'b0; mph = 2'd0;
        bus.sw  = 10'h000;
        bus.key = 4'hF;
        rst     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            settle("reset");
        end

        set_sw(10'h005);
        press(2'b01, 2, "enter_a");
        set_sw(10'h003);
        press(2'b01, 2, "enter_b");
        set_sw(10'h002);
        press(2'b01, 2, "enter_op");

        press(2'b01, 100, "wrap");

        set_sw(10'h005);
        for (int i = 0; i < 5; i++) begin
            bus.key[0] = 1'b0;
            tick();
            tick();
            bus.key[0] = 1'b1;
            tick();
            tick();
        end
        settle("bounce_quiet");
        press(2'b01, 3, "bounce");

        set_sw(10'h003);
        press(2'b01, 2, "enter_b2");
        set_sw(10'h000);
        settle("pre_clear");
        press(2'b11, 2, "clear");

        bus.sw = 10'h00F;
        tick();
        model_preview();
        settle("preview_follow");
        press(2'b01, 2, "enter_f");
        set_sw(10'h009);
        settle("frozen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
